snake_body_engine: RTL

//  Parametrised snake body tracker for the game update path. Holds segment coordinates in a

---
 rtl/snake_step_if.sv | 30 +++
 rtl/snake_body_engine.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/snake_step_if.sv
// Step handshake and status bundle between the game update logic and the snake body engine.
interface snake_step_if #(
  parameter int COORD_W = 10,
  parameter int LEN_W   = 7
);
  logic               step_valid;
  logic               step_ready;
  logic [1:0]         step_dir;
  logic               step_grow;
  logic               step_done;
  logic               dead;
  logic [COORD_W-1:0] head_x;
  logic [COORD_W-1:0] head_y;
  logic               free_valid;
  logic [COORD_W-1:0] free_x;
  logic [COORD_W-1:0] free_y;
  logic [LEN_W-1:0]   length;

  modport master (
    output step_valid, step_dir, step_grow,
    input  step_ready, step_done, dead, head_x, head_y,
    input  free_valid, free_x, free_y, length
  );

  modport slave (
    input  step_valid, step_dir, step_grow,
    output step_ready, step_done, dead, head_x, head_y,
    output free_valid, free_x, free_y, length
  );
endinterface

// File: rtl/snake_body_engine.sv
// Snake body tracker: ring buffer of segments, one handshaked move per step with a
// tail-to-head self-collision scan, wall/wrap handling and vacated-tail reporting.
module snake_body_engine #(
  parameter int COORD_W     = 10,
  parameter int MAX_LEN     = 64,
  parameter int INIT_LEN    = 3,
  parameter int INIT_X      = 20,
  parameter int INIT_Y      = 15,
  parameter int MAPA_WIDTH  = 40,
  parameter int MAPA_HEIGHT = 30,
  parameter int WRAP        = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           init,
  snake_step_if.slave    step
);
  localparam int PTR_W = $clog2(MAX_LEN);
  localparam int LEN_W = PTR_W + 1;

  localparam logic [1:0] S_INIT   = 2'd0;
  localparam logic [1:0] S_IDLE   = 2'd1;
  localparam logic [1:0] S_SCAN   = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  localparam logic [LEN_W-1:0]   LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]   LEN_INIT = LEN_W'(INIT_LEN);
  localparam logic [LEN_W-1:0]   LEN_ONE  = LEN_W'(1);
  localparam logic [PTR_W-1:0]   PTR_INIT = PTR_W'(INIT_LEN - 1);
  localparam logic [COORD_W-1:0] X0       = COORD_W'(INIT_X);
  localparam logic [COORD_W-1:0] Y0       = COORD_W'(INIT_Y);
  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(MAPA_WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(MAPA_HEIGHT - 1);

  // Returns {edge_crossed, next_coord}; the coordinate is already wrapped.
  function automatic logic [COORD_W:0] step_coord(input logic [COORD_W-1:0] c,
                                                  input logic inc, input logic dec,
                                                  input logic [COORD_W-1:0] last);
    logic [COORD_W:0] r;
    r = {1'b0, c};
    if (inc)
      r = (c == last) ? {1'b1, {COORD_W{1'b0}}} : {1'b0, c + 1'b1};
    else if (dec)
      r = (c == '0) ? {1'b1, last} : {1'b0, c - 1'b1};
    return r;
  endfunction

  logic [1:0]         state;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   cnt;
  logic [PTR_W-1:0]   head_ptr, tail_ptr, scan_ptr;
  logic [1:0]         cur_dir, mv_dir;
  logic               keep_tail, hit, dead_q, done_q, free_v;
  logic [COORD_W-1:0] hx, hy, fx, fy, nx, ny;
  logic [COORD_W-1:0] seg_x [MAX_LEN];
  logic [COORD_W-1:0] seg_y [MAX_LEN];

  logic               ready, accept, reverse, oob, grow_ok;
  logic [1:0]         eff_dir;
  logic [COORD_W:0]   xs, ys;
  logic [LEN_W-1:0]   scan_n;
  logic               wr_en;
  logic [PTR_W-1:0]   wr_ptr;
  logic [COORD_W-1:0] wr_x, wr_y;

  assign ready   = (state == S_IDLE) && !dead_q;
  assign accept  = step.step_valid && ready && !init;
  assign reverse = (step.step_dir[1] == cur_dir[1]) && (step.step_dir[0] != cur_dir[0]);
  assign eff_dir = (reverse && (len > LEN_ONE)) ? cur_dir : step.step_dir;
  assign xs      = step_coord(hx, eff_dir == 2'd2, eff_dir == 2'd3, X_LAST);
  assign ys      = step_coord(hy, eff_dir == 2'd1, eff_dir == 2'd0, Y_LAST);
  assign oob     = (WRAP == 0) && (xs[COORD_W] || ys[COORD_W]);
  assign grow_ok = step.step_grow && (len != LEN_MAX);
  // The tail entry is left out of the scan whenever it moves away this step.
  assign scan_n  = grow_ok ? len : len - LEN_ONE;

  always_comb begin
    wr_en  = 1'b0;
    wr_ptr = head_ptr + 1'b1;
    wr_x   = nx;
    wr_y   = ny;
    if (state == S_INIT) begin
      wr_en  = 1'b1;
      wr_ptr = PTR_INIT - cnt[PTR_W-1:0];
      wr_x   = X0 - COORD_W'(cnt);
      wr_y   = Y0;
    end else if (state == S_COMMIT && !hit) begin
      wr_en  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      seg_x[wr_ptr] <= wr_x;
      seg_y[wr_ptr] <= wr_y;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      nx <= xs[COORD_W-1:0];
      ny <= ys[COORD_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_INIT;
      len       <= '0;
      cnt       <= '0;
      head_ptr  <= '0;
      tail_ptr  <= '0;
      scan_ptr  <= '0;
      cur_dir   <= 2'd2;
      mv_dir    <= 2'd2;
      keep_tail <= 1'b0;
      hit       <= 1'b0;
      dead_q    <= 1'b0;
      done_q    <= 1'b0;
      free_v    <= 1'b0;
      hx        <= X0;
      hy        <= Y0;
      fx        <= '0;
      fy        <= '0;
    end else begin
      done_q <= 1'b0;
      free_v <= 1'b0;
      if (init) begin
        state   <= S_INIT;
        len     <= '0;
        cnt     <= '0;
        cur_dir <= 2'd2;
        hit     <= 1'b0;
        dead_q  <= 1'b0;
        hx      <= X0;
        hy      <= Y0;
        fx      <= '0;
        fy      <= '0;
      end else begin
        case (state)
          S_INIT: begin
            len <= len + 1'b1;
            cnt <= cnt + 1'b1;
            if (cnt == LEN_INIT - LEN_ONE) begin
              state    <= S_IDLE;
              head_ptr <= PTR_INIT;
              tail_ptr <= '0;
            end
          end
          S_IDLE: begin
            if (accept) begin
              mv_dir    <= eff_dir;
              keep_tail <= grow_ok;
              hit       <= oob;
              scan_ptr  <= grow_ok ? tail_ptr : tail_ptr + 1'b1;
              cnt       <= scan_n;
              state     <= (oob || scan_n == '0) ? S_COMMIT : S_SCAN;
            end
          end
          S_SCAN: begin
            if (seg_x[scan_ptr] == nx && seg_y[scan_ptr] == ny)
              hit <= 1'b1;
            scan_ptr <= scan_ptr + 1'b1;
            cnt      <= cnt - LEN_ONE;
            if (cnt == LEN_ONE)
              state <= S_COMMIT;
          end
          default: begin
            done_q <= 1'b1;
            state  <= S_IDLE;
            if (hit) begin
              dead_q <= 1'b1;
            end else begin
              head_ptr <= head_ptr + 1'b1;
              hx       <= nx;
              hy       <= ny;
              cur_dir  <= mv_dir;
              if (keep_tail) begin
                len <= len + 1'b1;
              end else begin
                tail_ptr <= tail_ptr + 1'b1;
                free_v   <= 1'b1;
                fx       <= seg_x[tail_ptr];
                fy       <= seg_y[tail_ptr];
              end
            end
          end
        endcase
      end
    end
  end

  assign step.step_ready = ready;
  assign step.step_done  = done_q;
  assign step.dead       = dead_q;
  assign step.head_x     = hx;
  assign step.head_y     = hy;
  assign step.free_valid = free_v;
  assign step.free_x     = fx;
  assign step.free_y     = fy;
  assign step.length     = len;
endmodule
